acc_mem_responder: RTL and testbench
====================================

Name: acc_mem_responder

Overview:
- Memory-side responder for the SHA-256 accelerator's memory interface; the other end of the accelerator's read/write/listen ports.
- Owns a word-addressed backing SRAM.
- Serves 512-bit line reads (one SHA block) and 32-bit word writes from the accelerator.
- Accepts host (CPU) word writes and mirrors each one onto the accelerator's listen port.

Parameters:
- ADDR_W, 16, width of word addresses on all ports.
- DEPTH_LOG2, 12, log2 of SRAM depth in 32-bit words (4096 words); address bits above DEPTH_LOG2 ignored (wrap).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- host_wr_en  in  1  host word-write strobe, always accepted
- host_wr_addr  in  ADDR_W  host write word address
- host_wr_data  in  32  host write data
- mem_listen_en  out  1  mirror strobe of accepted host write
- mem_listen_addr  out  ADDR_W  mirrored address
- mem_listen_data  out  32  mirrored data
- mem_acc_read_en  in  1  line-read request pulse
- mem_acc_read_addr  in  ADDR_W  line word address; low 4 bits ignored (16-word aligned)
- mem_acc_read_data  out  512  line data; lowest-address word in [511:480], word k in [511-32k -: 32]
- mem_acc_read_data_valid  out  1  one-cycle pulse, line data valid
- mem_acc_write_en  in  1  word-write request pulse
- mem_acc_write_addr  in  ADDR_W  write word address
- mem_acc_write_data  in  32  write data
- mem_acc_write_done  out  1  one-cycle pulse, write committed
- acc_busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, fetch counter 0. SRAM contents not reset. Reset mid-operation abandons the transfer; no valid/done pulse follows.
- SRAM: single port, one access per cycle, 1-cycle read latency.
- Port priority: a host write always takes the SRAM port. A colliding accelerator access stalls one cycle per host write; counters and state hold.
- Listen mirror: a host write accepted at cycle T drives mem_listen_en=1 with registered addr/data at T+1. Back-to-back host writes give back-to-back pulses.
- States: IDLE, RD_FETCH, RD_RESP, WR, WR_DONE.
- IDLE:
  - Samples requests. read_en goes to RD_FETCH, latching base = addr with [3:0] cleared.
  - write_en goes to WR, latching addr and data.
  - Both high: write wins; read is latched as pending and started on WR_DONE→IDLE→RD_FETCH without a new pulse.
  - The accelerator may pulse only while acc_busy=0. Pulses while busy are ignored.
- RD_FETCH:
  - Issues base+0..base+15, one per unstalled cycle.
  - Returned words shift into the line register at their slot.
  - Leaves after the 16th word is captured.
  - Unstalled, a request sampled at T gives valid at T+18.
- RD_RESP: pulses mem_acc_read_data_valid for exactly one cycle, then returns to IDLE. mem_acc_read_data holds until the next read's RD_RESP.
- WR: commits the word when the port is free. Goes to WR_DONE, which pulses mem_acc_write_done for one cycle, then IDLE. Unstalled: request at T, done at T+2.
- Coherence: each line word reflects SRAM at the cycle it was fetched. A host write to an already-fetched word is not reflected.
- Address wrap: base+k computed modulo 2^DEPTH_LOG2.

Test Plan:
- Reset, then host writes 0x00000000..0x0000000F to addrs 0x0010..0x001F → listen pulses 1 cycle after each with matching addr/data. Read at 0x0013 (aligned to 0x0010) → valid exactly 18 cycles later; data[511:480]=0, data[31:0]=0xF.
- Accelerator write 0xDEADBEEF to 0x0200 at T → done pulse at T+2, acc_busy high T+1..T+2. Subsequent line read at 0x0200 → data[511:480]=0xDEADBEEF.
- Read and write pulsed in the same IDLE cycle → write done first, then read valid without re-request; line includes the new word.
- Host write every cycle for 3 cycles during RD_FETCH → valid delayed by exactly 3 cycles; listen port mirrors all 3 writes.
- Read at 0x0FF8 with DEPTH_LOG2=12 → words fetched from 0x0FF0..0x0FFF. Read at 0x1010 → same data as 0x0010.
- rst_n low mid RD_FETCH → no valid pulse, outputs 0 and acc_busy 0 from the cycle after reset. Earlier SRAM data still readable afterwards.

Source files
------------

// File: rtl/acc_mem_if.sv
// Accelerator-facing memory bus of the SHA-256 memory responder: line reads,
// word writes, and the listen mirror of host writes.
interface acc_mem_if #(
  parameter int ADDR_W = 16
);
  logic              mem_listen_en;
  logic [ADDR_W-1:0] mem_listen_addr;
  logic [31:0]       mem_listen_data;

  logic              mem_acc_read_en;
  logic [ADDR_W-1:0] mem_acc_read_addr;
  logic [511:0]      mem_acc_read_data;
  logic              mem_acc_read_data_valid;

  logic              mem_acc_write_en;
  logic [ADDR_W-1:0] mem_acc_write_addr;
  logic [31:0]       mem_acc_write_data;
  logic              mem_acc_write_done;

  logic              acc_busy;

  // Accelerator side
  modport master (
    input  mem_listen_en, mem_listen_addr, mem_listen_data,
    input  mem_acc_read_data, mem_acc_read_data_valid,
    input  mem_acc_write_done, acc_busy,
    output mem_acc_read_en, mem_acc_read_addr,
    output mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data
  );

  // Memory responder side
  modport slave (
    output mem_listen_en, mem_listen_addr, mem_listen_data,
    output mem_acc_read_data, mem_acc_read_data_valid,
    output mem_acc_write_done, acc_busy,
    input  mem_acc_read_en, mem_acc_read_addr,
    input  mem_acc_write_en, mem_acc_write_addr, mem_acc_write_data
  );
endinterface

// File: rtl/acc_mem_responder.sv
// Memory-side responder for the SHA-256 accelerator: single-port word SRAM
// serving 16-word line reads and word writes, with host writes taking priority.
module acc_mem_responder #(
  parameter int ADDR_W     = 16,
  parameter int DEPTH_LOG2 = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_wr_en,
  input  logic [ADDR_W-1:0] host_wr_addr,
  input  logic [31:0]       host_wr_data,
  acc_mem_if.slave          bus
);

  typedef enum logic [2:0] {IDLE, RD_FETCH, RD_RESP, WR, WR_DONE} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                  state;
  logic [31:0]             mem [DEPTH];
  logic [31:0]             rdata_q;
  logic [DEPTH_LOG2-5:0]   base_q;      // line index; word offset comes from issue_cnt
  logic                    rd_pend_q;
  logic [4:0]              issue_cnt;
  logic [3:0]              cap_cnt;
  logic                    cap_vld_q;
  logic [511:0]            line_q;
  logic [DEPTH_LOG2-1:0]   wr_idx_q;
  logic [31:0]             wr_data_q;

  logic                    port_we;
  logic                    port_re;
  logic [DEPTH_LOG2-1:0]   port_idx;
  logic [31:0]             port_wdata;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.mem_acc_read_addr[ADDR_W-1:DEPTH_LOG2],
                              bus.mem_acc_read_addr[3:0],
                              bus.mem_acc_write_addr[ADDR_W-1:DEPTH_LOG2]};

  // Single SRAM port arbitration: host write, then accelerator write, then fetch.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned and infers a latch.
    port_we    = 1'b0;
    port_re    = 1'b0;
    port_idx   = host_wr_addr[DEPTH_LOG2-1:0];
    port_wdata = host_wr_data;
    if (host_wr_en) begin
      port_we = 1'b1;
    end else if (state == WR) begin
      port_we    = 1'b1;
      port_idx   = wr_idx_q;
      port_wdata = wr_data_q;
    end else if (state == RD_FETCH && !issue_cnt[4]) begin
      port_re  = 1'b1;
      port_idx = {base_q, issue_cnt[3:0]};
    end
  end

  // NOTE: SRAM arrays carry no reset; contents survive rst_n and only the control path restarts.
  always_ff @(posedge clk) begin
    if (port_we) mem[port_idx] <= port_wdata;
    if (port_re) rdata_q <= mem[port_idx];
  end

  // NOTE: all sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state                       <= IDLE;
      base_q                      <= '0;
      rd_pend_q                   <= 1'b0;
      issue_cnt                   <= '0;
      cap_cnt                     <= '0;
      cap_vld_q                   <= 1'b0;
      line_q                      <= '0;
      wr_idx_q                    <= '0;
      wr_data_q                   <= '0;
      bus.mem_listen_en           <= 1'b0;
      bus.mem_listen_addr         <= '0;
      bus.mem_listen_data         <= '0;
      bus.mem_acc_read_data       <= '0;
      bus.mem_acc_read_data_valid <= 1'b0;
      bus.mem_acc_write_done      <= 1'b0;
      bus.acc_busy                <= 1'b0;
    end else begin
      bus.mem_listen_en <= host_wr_en;
      if (host_wr_en) begin
        bus.mem_listen_addr <= host_wr_addr;
        bus.mem_listen_data <= host_wr_data;
      end
      bus.mem_acc_read_data_valid <= 1'b0;
      bus.mem_acc_write_done      <= 1'b0;

      // Words return in address order, so shifting in lands word 0 at the top.
      cap_vld_q <= port_re;
      if (cap_vld_q) begin
        line_q  <= {line_q[479:0], rdata_q};
        cap_cnt <= cap_cnt + 4'd1;
      end

      case (state)
        IDLE: begin
          issue_cnt <= '0;
          cap_cnt   <= '0;
          if (rd_pend_q) begin
            rd_pend_q    <= 1'b0;
            state        <= RD_FETCH;
            bus.acc_busy <= 1'b1;
          end else if (bus.mem_acc_write_en) begin
            wr_idx_q     <= bus.mem_acc_write_addr[DEPTH_LOG2-1:0];
            wr_data_q    <= bus.mem_acc_write_data;
            state        <= WR;
            bus.acc_busy <= 1'b1;
            if (bus.mem_acc_read_en) begin
              rd_pend_q <= 1'b1;
              base_q    <= bus.mem_acc_read_addr[DEPTH_LOG2-1:4];
            end
          end else if (bus.mem_acc_read_en) begin
            base_q       <= bus.mem_acc_read_addr[DEPTH_LOG2-1:4];
            state        <= RD_FETCH;
            bus.acc_busy <= 1'b1;
          end
        end
        RD_FETCH: begin
          if (port_re) issue_cnt <= issue_cnt + 5'd1;
          if (cap_vld_q && cap_cnt == 4'd15) begin
            bus.mem_acc_read_data       <= {line_q[479:0], rdata_q};
            bus.mem_acc_read_data_valid <= 1'b1;
            state                       <= RD_RESP;
          end
        end
        RD_RESP: begin
          state        <= IDLE;
          bus.acc_busy <= 1'b0;
        end
        WR: begin
          if (!host_wr_en) begin
            bus.mem_acc_write_done <= 1'b1;
            state                  <= WR_DONE;
          end
        end
        WR_DONE: begin
          state        <= IDLE;
          bus.acc_busy <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          bus.acc_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_mem_responder.sv
// Directed self-checking bench for acc_mem_responder: latency, priority,
// stalls, address wrap and mid-fetch reset against a small SRAM model.
module tb_acc_mem_responder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        host_wr_en;
  logic [15:0] host_wr_addr;
  logic [31:0] host_wr_data;

  acc_mem_if #(.ADDR_W(16)) bus ();

  acc_mem_responder #(.ADDR_W(16), .DEPTH_LOG2(12)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] mem_m [4096];

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [511:0] exp_line(input logic [15:0] addr);
    logic [511:0] l;
    logic [11:0]  base;
    base = {addr[11:4], 4'h0};
    for (int k = 0; k < 16; k++) l[511-32*k -: 32] = mem_m[base + 12'(k)];
    return l;
  endfunction

  task automatic host_write(input logic [15:0] a, input logic [31:0] d);
    host_wr_en = 1'b1; host_wr_addr = a; host_wr_data = d;
    mem_m[a[11:0]] = d;
    tick();
    host_wr_en = 1'b0;
    check("listen_en", 512'(bus.mem_listen_en), 512'(1'b1));
    check("listen_addr", 512'(bus.mem_listen_addr), 512'(a));
    check("listen_data", 512'(bus.mem_listen_data), 512'(d));
  endtask

  // Drives one request cycle, optional host writes at cycles [h_start, h_start+h_cnt),
  // and reports the cycle offsets of done/valid (-1 if never seen) plus a busy trace.
  task automatic run_req(input logic rd, input logic [15:0] rd_a,
                         input logic wr, input logic [15:0] wr_a, input logic [31:0] wr_d,
                         input int h_start, input int h_cnt, input logic [15:0] h_a,
                         output int done_at, output int valid_at, output logic [63:0] busy_tr);
    logic hdrv;
    done_at = -1; valid_at = -1; busy_tr = '0;
    bus.mem_acc_read_en = rd;  bus.mem_acc_read_addr = rd_a;
    bus.mem_acc_write_en = wr; bus.mem_acc_write_addr = wr_a; bus.mem_acc_write_data = wr_d;
    if (wr) mem_m[wr_a[11:0]] = wr_d;
    for (int c = 0; c < 60; c++) begin
      hdrv = (c >= h_start) && (c < h_start + h_cnt);
      host_wr_en = hdrv;
      host_wr_addr = h_a + 16'(c - h_start);
      host_wr_data = 32'hA0 + 32'(c - h_start);
      if (hdrv) mem_m[host_wr_addr[11:0]] = host_wr_data;
      tick();
      bus.mem_acc_read_en = 1'b0; bus.mem_acc_write_en = 1'b0; host_wr_en = 1'b0;
      if (hdrv) begin
        check("stall_listen_en", 512'(bus.mem_listen_en), 512'(1'b1));
        check("stall_listen_addr", 512'(bus.mem_listen_addr), 512'(h_a + 16'(c - h_start)));
        check("stall_listen_data", 512'(bus.mem_listen_data), 512'(32'hA0 + 32'(c - h_start)));
      end
      busy_tr[c+1] = bus.acc_busy;
      if (bus.mem_acc_write_done && done_at < 0) done_at = c + 1;
      if (bus.mem_acc_read_data_valid && valid_at < 0) valid_at = c + 1;
      if ((!rd || valid_at >= 0) && (!wr || done_at >= 0) && busy_tr[c+1] == 1'b0 && c > 0) break;
    end
  endtask

  int done_at, valid_at, seen;
  logic [63:0] busy_tr;
  logic [511:0] line;

  initial begin
    rst_n = 1'b0; host_wr_en = 1'b0; host_wr_addr = '0; host_wr_data = '0;
    bus.mem_acc_read_en = 1'b0; bus.mem_acc_read_addr = '0;
    bus.mem_acc_write_en = 1'b0; bus.mem_acc_write_addr = '0; bus.mem_acc_write_data = '0;
    tick(); tick();
    check("rst_busy", 512'(bus.acc_busy), 512'(1'b0));
    check("rst_valid", 512'(bus.mem_acc_read_data_valid), 512'(1'b0));
    check("rst_done", 512'(bus.mem_acc_write_done), 512'(1'b0));
    check("rst_listen", 512'(bus.mem_listen_en), 512'(1'b0));
    check("rst_rdata", bus.mem_acc_read_data, 512'(0));
    rst_n = 1'b1;
    tick();

    // Back-to-back host writes, then a line read at an unaligned address.
    for (int i = 0; i < 16; i++) host_write(16'h0010 + 16'(i), 32'(i));
    tick();
    check("listen_idle", 512'(bus.mem_listen_en), 512'(1'b0));
    run_req(1'b1, 16'h0013, 1'b0, '0, '0, 99, 0, '0, done_at, valid_at, busy_tr);
    check("rd_latency", 512'(valid_at), 512'(18));
    check("rd_word0", 512'(bus.mem_acc_read_data[511:480]), 512'(32'h0));
    check("rd_word15", 512'(bus.mem_acc_read_data[31:0]), 512'(32'hF));
    check("rd_line", bus.mem_acc_read_data, exp_line(16'h0010));
    tick(); tick();
    check("rd_valid_pulse", 512'(bus.mem_acc_read_data_valid), 512'(1'b0));
    check("rd_hold", bus.mem_acc_read_data, exp_line(16'h0010));

    // Accelerator word write, then read back its line.
    for (int i = 0; i < 16; i++) host_write(16'h0200 + 16'(i), 32'h2000 + 32'(i));
    run_req(1'b0, '0, 1'b1, 16'h0200, 32'hDEADBEEF, 99, 0, '0, done_at, valid_at, busy_tr);
    check("wr_done_at", 512'(done_at), 512'(2));
    check("wr_busy_trace", 512'(busy_tr[3:0]), 512'(4'b0110));
    run_req(1'b1, 16'h0200, 1'b0, '0, '0, 99, 0, '0, done_at, valid_at, busy_tr);
    check("wr_readback", 512'(bus.mem_acc_read_data[511:480]), 512'(32'hDEADBEEF));

    // Simultaneous read and write: write first, read follows without re-request.
    run_req(1'b1, 16'h0200, 1'b1, 16'h0205, 32'hCAFEF00D, 99, 0, '0, done_at, valid_at, busy_tr);
    check("both_done_at", 512'(done_at), 512'(2));
    check("both_valid_at", 512'(valid_at), 512'(21));
    check("both_line", bus.mem_acc_read_data, exp_line(16'h0200));
    check("both_word5", 512'(bus.mem_acc_read_data[351:320]), 512'(32'hCAFEF00D));

    // Three host writes during the fetch stall it by three cycles.
    run_req(1'b1, 16'h0010, 1'b0, '0, '0, 3, 3, 16'h0300, done_at, valid_at, busy_tr);
    check("stall_valid_at", 512'(valid_at), 512'(21));
    check("stall_line", bus.mem_acc_read_data, exp_line(16'h0010));

    // Address wrap at the top of the SRAM and above DEPTH.
    for (int i = 0; i < 16; i++) host_write(16'h0FF0 + 16'(i), 32'h0F00 + 32'(i));
    run_req(1'b1, 16'h0FF8, 1'b0, '0, '0, 99, 0, '0, done_at, valid_at, busy_tr);
    check("wrap_top_line", bus.mem_acc_read_data, exp_line(16'h0FF0));
    check("wrap_top_w0", 512'(bus.mem_acc_read_data[511:480]), 512'(32'h0F00));
    run_req(1'b1, 16'h1010, 1'b0, '0, '0, 99, 0, '0, done_at, valid_at, busy_tr);
    check("wrap_alias_line", bus.mem_acc_read_data, exp_line(16'h0010));

    // Reset mid fetch abandons the read; SRAM contents survive.
    bus.mem_acc_read_en = 1'b1; bus.mem_acc_read_addr = 16'h0200;
    tick();
    bus.mem_acc_read_en = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_busy", 512'(bus.acc_busy), 512'(1'b0));
    check("mid_rst_valid", 512'(bus.mem_acc_read_data_valid), 512'(1'b0));
    check("mid_rst_rdata", bus.mem_acc_read_data, 512'(0));
    check("mid_rst_done", 512'(bus.mem_acc_write_done), 512'(1'b0));
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.mem_acc_read_data_valid || bus.acc_busy) seen++;
    end
    check("mid_rst_no_pulse", 512'(seen), 512'(0));
    run_req(1'b1, 16'h0010, 1'b0, '0, '0, 99, 0, '0, done_at, valid_at, busy_tr);
    check("post_rst_latency", 512'(valid_at), 512'(18));
    check("post_rst_line", bus.mem_acc_read_data, exp_line(16'h0010));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
